addr_calcu_pipe: RTL and testbench

Pipelined, multi-channel successor to the base-relative address calculator. Holds a register file of NCH channels × 2 pointer banks. For each accepted request it computes count = address − (BASE − ptr) + b, where `control` is a late-arriving select between the channel's two banks. Optionally post-increments the used pointer with wrap. Sits between the request issuer and the memory-address consumer behind valid/ready handshakes on both sides.

---
 rtl/addr_calcu_pipe_pkg.sv | 27 ++
 rtl/addr_ptr_bank.sv | 65 ++++++
 rtl/addr_calcu_pipe.sv | 138 +++++++++++++
 tb/tb_addr_calcu_pipe.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/addr_calcu_pipe_pkg.sv
// Shared defaults, channel index type and the base-relative offset helper
// for the pipelined address calculator.
package addr_calcu_pipe_pkg;

   localparam int DEF_W       = 8;
   localparam int DEF_NCH     = 4;
   localparam int DEF_BASE    = 1 << (DEF_W - 1);
   localparam int DEF_PTR_MAX = (1 << DEF_W) - 1;

   function automatic int ch_width(input int nch);
      return (nch > 1) ? $clog2(nch) : 1;
   endfunction

   localparam int DEF_CHW = ch_width(DEF_NCH);

   typedef logic [DEF_CHW-1:0] ch_idx_t;

   // (base - ptr) reduced modulo 2^w; callers keep the low w bits.
   function automatic logic [31:0] ptr_offset(input logic [31:0] base,
                                              input logic [31:0] ptr,
                                              input int unsigned w);
      logic [31:0] mask;
      mask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
      return (base - ptr) & mask;
   endfunction

endpackage

// File: rtl/addr_ptr_bank.sv
// NCH x 2 pointer register file: one write port, one wrapping increment port
// (write has priority) and a combinational read of both banks of one channel.
module addr_ptr_bank
   import addr_calcu_pipe_pkg::*;
#(
   parameter int W                = DEF_W,
   parameter int NCH              = DEF_NCH,
   parameter logic [W-1:0] PTR_MAX = '1,
   localparam int CHW             = ch_width(NCH)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           we,
   input  logic [CHW-1:0] wch,
   input  logic           wbank,
   input  logic [W-1:0]   wdata,
   input  logic           inc_en,
   input  logic [CHW-1:0] inc_ch,
   input  logic           inc_bank,
   input  logic [CHW-1:0] rd_ch,
   output logic [W-1:0]   rd_a,
   output logic [W-1:0]   rd_b
);

   // Entry 2*ch+1 is bank A, entry 2*ch is bank B.
   logic [W-1:0] ptr_flat [NCH*2];

   generate
      for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
         for (genvar gj = 0; gj < 2; gj++) begin : g_bank
            logic [W-1:0] ptr_reg;
            logic         wr_hit;
            logic         inc_hit;

            // Out-of-range channel numbers match no entry, so they are ignored.
            assign wr_hit  = we && (wch == CHW'(gi)) && (wbank == 1'(gj));
            assign inc_hit = inc_en && (inc_ch == CHW'(gi)) && (inc_bank == 1'(gj));

            always_ff @(posedge clk) begin
               if (!rst_n) begin
                  ptr_reg <= '0;
               end else if (wr_hit) begin
                  ptr_reg <= wdata;
               end else if (inc_hit) begin
                  ptr_reg <= (ptr_reg == PTR_MAX) ? '0 : ptr_reg + 1'b1;
               end
            end

            assign ptr_flat[gi*2+gj] = ptr_reg;
         end
      end
   endgenerate

   always_comb begin
      rd_a = '0;
      rd_b = '0;
      for (int i = 0; i < NCH; i++) begin
         if (rd_ch == CHW'(i)) begin
            rd_a = ptr_flat[2*i+1];
            rd_b = ptr_flat[2*i];
         end
      end
   end

endmodule

// File: rtl/addr_calcu_pipe.sv
// Two-stage valid/ready pipeline computing count = address - (BASE - ptr) + b
// with a late bank select resolved only after the first register.
module addr_calcu_pipe
   import addr_calcu_pipe_pkg::*;
#(
   parameter int W                 = DEF_W,
   parameter int CW                = 2 * W,
   parameter int NCH               = DEF_NCH,
   parameter logic [W-1:0] BASE    = W'(1 << (W - 1)),
   parameter logic [W-1:0] PTR_MAX = '1,
   localparam int CHW              = ch_width(NCH)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [W-1:0]   address,
   input  logic [W-1:0]   b,
   input  logic [CHW-1:0] ch_sel,
   input  logic           control,
   input  logic           auto_inc,
   input  logic           ptr_we,
   input  logic [CHW-1:0] ptr_wch,
   input  logic           ptr_wbank,
   input  logic [W-1:0]   ptr_wdata,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [CW-1:0]  count,
   output logic [CHW-1:0] out_ch
);

   logic           s1_valid_reg;
   logic [W-1:0]   s1_addr_reg;
   logic [W-1:0]   s1_b_reg;
   logic [W-1:0]   s1_off_a_reg;
   logic [W-1:0]   s1_off_b_reg;
   logic [CHW-1:0] s1_ch_reg;
   logic           s1_ctrl_reg;

   logic           out_valid_reg;
   logic [CW-1:0]  count_reg;
   logic [CHW-1:0] out_ch_reg;

   logic           adv2;
   logic           accept;
   logic [W-1:0]   rd_a;
   logic [W-1:0]   rd_b;
   logic [31:0]    off_a_full;
   logic [31:0]    off_b_full;
   logic [W-1:0]   off_a;
   logic [W-1:0]   off_b;
   logic [W-1:0]   sel_off;
   logic [CW-1:0]  count_next;

   assign adv2     = !out_valid_reg || out_ready;
   assign in_ready = !s1_valid_reg || adv2;
   assign accept   = in_valid && in_ready;

   // The increment bank follows control; only state, never the datapath, uses it early.
   addr_ptr_bank #(
      .W       (W),
      .NCH     (NCH),
      .PTR_MAX (PTR_MAX)
   ) u_ptr_bank (
      .clk      (clk),
      .rst_n    (rst_n),
      .we       (ptr_we),
      .wch      (ptr_wch),
      .wbank    (ptr_wbank),
      .wdata    (ptr_wdata),
      .inc_en   (accept && auto_inc),
      .inc_ch   (ch_sel),
      .inc_bank (control),
      .rd_ch    (ch_sel),
      .rd_a     (rd_a),
      .rd_b     (rd_b)
   );

   assign off_a_full = ptr_offset(32'(BASE), 32'(rd_a), W);
   assign off_b_full = ptr_offset(32'(BASE), 32'(rd_b), W);
   assign off_a      = off_a_full[W-1:0];
   assign off_b      = off_b_full[W-1:0];

   generate
      if (W < 32) begin : g_off_hi
         logic unused_off_hi;
         assign unused_off_hi = ^{off_a_full[31:W], off_b_full[31:W]};
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid_reg <= 1'b0;
         s1_addr_reg  <= '0;
         s1_b_reg     <= '0;
         s1_off_a_reg <= '0;
         s1_off_b_reg <= '0;
         s1_ch_reg    <= '0;
         s1_ctrl_reg  <= 1'b0;
      end else if (in_ready) begin
         s1_valid_reg <= in_valid;
         if (in_valid) begin
            s1_addr_reg  <= address;
            s1_b_reg     <= b;
            s1_off_a_reg <= off_a;
            s1_off_b_reg <= off_b;
            s1_ch_reg    <= ch_sel;
            s1_ctrl_reg  <= control;
         end
      end
   end

   always_comb begin
      sel_off    = s1_ctrl_reg ? s1_off_a_reg : s1_off_b_reg;
      count_next = {{(CW-W){1'b0}}, s1_addr_reg}
                 - {{(CW-W){1'b0}}, sel_off}
                 + {{(CW-W){1'b0}}, s1_b_reg};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_reg <= 1'b0;
         count_reg     <= '0;
         out_ch_reg    <= '0;
      end else if (adv2) begin
         out_valid_reg <= s1_valid_reg;
         if (s1_valid_reg) begin
            count_reg  <= count_next;
            out_ch_reg <= s1_ch_reg;
         end
      end
   end

   assign out_valid = out_valid_reg;
   assign count     = count_reg;
   assign out_ch    = out_ch_reg;

endmodule

// File: tb/tb_addr_calcu_pipe.sv
// Directed bench for addr_calcu_pipe (W=8, NCH=4) with hand-computed results.
module tb_addr_calcu_pipe;
   import addr_calcu_pipe_pkg::*;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [7:0]    address = '0;
   logic [7:0]    b = '0;
   ch_idx_t       ch_sel = '0;
   logic          control = 1'b0;
   logic          auto_inc = 1'b0;
   logic          ptr_we = 1'b0;
   ch_idx_t       ptr_wch = '0;
   logic          ptr_wbank = 1'b0;
   logic [7:0]    ptr_wdata = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [15:0]   count;
   ch_idx_t       out_ch;

   int checks = 0;
   int passes = 0;

   logic [15:0] bp_exp [5] = '{16'h0040, 16'h0042, 16'h0044, 16'h0046, 16'h0048};

   addr_calcu_pipe dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .address   (address),
      .b         (b),
      .ch_sel    (ch_sel),
      .control   (control),
      .auto_inc  (auto_inc),
      .ptr_we    (ptr_we),
      .ptr_wch   (ptr_wch),
      .ptr_wbank (ptr_wbank),
      .ptr_wdata (ptr_wdata),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .count     (count),
      .out_ch    (out_ch)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic wr_ptr(input ch_idx_t ch, input logic bank, input logic [7:0] val);
      ptr_we    = 1'b1;
      ptr_wch   = ch;
      ptr_wbank = bank;
      ptr_wdata = val;
      tick();
      ptr_we    = 1'b0;
   endtask

   task automatic set_req(input ch_idx_t ch, input logic ctrl, input logic inc,
                          input logic [7:0] a, input logic [7:0] bb);
      in_valid = 1'b1;
      ch_sel   = ch;
      control  = ctrl;
      auto_inc = inc;
      address  = a;
      b        = bb;
   endtask

   task automatic idle();
      in_valid = 1'b0;
      auto_inc = 1'b0;
   endtask

   // Isolated request: accept, one stage, then result sits in the output register.
   task automatic one_req(input ch_idx_t ch, input logic ctrl, input logic inc,
                          input logic [7:0] a, input logic [7:0] bb);
      set_req(ch, ctrl, inc, a, bb);
      tick();
      idle();
      tick();
   endtask

   task automatic expect_out(input string tag, input logic [15:0] exp_count, input ch_idx_t exp_ch);
      $display("result %s: out_valid=%0b ch=%0d count=%h (want ch=%0d count=%h)",
               tag, out_valid, out_ch, count, exp_ch, exp_count);
      check({tag, "_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_count"}, 32'(count), 32'(exp_count));
      check({tag, "_ch"}, 32'(out_ch), 32'(exp_ch));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int sent;
      int rcv;

      // Reset
      rst_n = 1'b0;
      tick();
      tick();
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_count", 32'(count), 32'd0);
      rst_n = 1'b1;
      tick();
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid_after", 32'(out_valid), 32'd0);

      // Basic: A offset 0x60, B offset 0x40
      wr_ptr(2'd1, 1'b1, 8'h20);
      wr_ptr(2'd1, 1'b0, 8'h40);
      set_req(2'd1, 1'b1, 1'b0, 8'h90, 8'h05);
      check("basic_in_ready", 32'(in_ready), 32'd1);
      tick();
      check("basic_latency", 32'(out_valid), 32'd0);
      set_req(2'd1, 1'b0, 1'b0, 8'h90, 8'h05);
      tick();
      idle();
      expect_out("basic_a", 16'h0035, 2'd1);
      tick();
      expect_out("basic_b", 16'h0055, 2'd1);
      tick();
      check("basic_drain", 32'(out_valid), 32'd0);

      // Underflow with zero pointer, and carry past W bits
      one_req(2'd3, 1'b1, 1'b0, 8'h10, 8'h00);
      expect_out("underflow", 16'hFF90, 2'd3);
      wr_ptr(2'd3, 1'b0, 8'h80);
      one_req(2'd3, 1'b0, 1'b0, 8'hFF, 8'hFF);
      expect_out("carry", 16'h01FE, 2'd3);

      // Auto-increment wrap on ptr[2][B]
      wr_ptr(2'd2, 1'b0, 8'hFF);
      set_req(2'd2, 1'b0, 1'b1, 8'h80, 8'h00);
      tick();
      set_req(2'd2, 1'b0, 1'b1, 8'h80, 8'h00);
      tick();
      idle();
      expect_out("wrap_first", 16'hFFFF, 2'd2);
      tick();
      expect_out("wrap_second", 16'h0000, 2'd2);
      one_req(2'd2, 1'b0, 1'b0, 8'h80, 8'h00);
      expect_out("wrap_final_ptr", 16'h0001, 2'd2);

      // Write and increment hitting ptr[0][A] in the same cycle
      wr_ptr(2'd0, 1'b1, 8'h05);
      ptr_we    = 1'b1;
      ptr_wch   = 2'd0;
      ptr_wbank = 1'b1;
      ptr_wdata = 8'h10;
      set_req(2'd0, 1'b1, 1'b1, 8'h80, 8'h00);
      tick();
      ptr_we = 1'b0;
      idle();
      tick();
      expect_out("collide_old", 16'h0005, 2'd0);
      one_req(2'd0, 1'b1, 1'b0, 8'h80, 8'h00);
      expect_out("collide_write_wins", 16'h0010, 2'd0);
      tick();

      // Backpressure: out_ready low for cycles 3..5
      sent = 0;
      rcv  = 0;
      for (int c = 0; c < 30 && rcv < 5; c++) begin
         out_ready = !(c >= 3 && c <= 5);
         if (sent < 5) set_req(2'd1, 1'b1, 1'b0, 8'hA0 + 8'(sent), 8'(sent));
         else idle();
         #1;
         if (c == 3) check("bp_in_ready_drop", 32'(in_ready), 32'd0);
         if (out_valid) begin
            $display("stream cycle %0d: idx=%0d count=%h out_ready=%0b", c, rcv, count, out_ready);
            check("bp_count", 32'(count), 32'(bp_exp[rcv]));
            check("bp_ch", 32'(out_ch), 32'd1);
            if (out_ready) rcv++;
         end
         if (in_valid && in_ready) sent++;
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      idle();
      check("bp_all_received", 32'(rcv), 32'd5);
      check("bp_all_sent", 32'(sent), 32'd5);
      check("bp_no_dup", 32'(out_valid), 32'd0);
      tick();
      check("bp_no_dup_late", 32'(out_valid), 32'd0);

      // Reset with two requests in flight
      set_req(2'd1, 1'b1, 1'b0, 8'h90, 8'h05);
      tick();
      set_req(2'd1, 1'b0, 1'b0, 8'h90, 8'h05);
      tick();
      idle();
      check("rs_pre_valid", 32'(out_valid), 32'd1);
      rst_n = 1'b0;
      tick();
      check("rs_out_valid", 32'(out_valid), 32'd0);
      check("rs_count", 32'(count), 32'd0);
      check("rs_out_ch", 32'(out_ch), 32'd0);
      check("rs_in_ready", 32'(in_ready), 32'd1);
      rst_n = 1'b1;
      tick();
      check("rs_no_stale_1", 32'(out_valid), 32'd0);
      tick();
      check("rs_no_stale_2", 32'(out_valid), 32'd0);
      one_req(2'd1, 1'b1, 1'b0, 8'h10, 8'h00);
      expect_out("rs_ptr_cleared", 16'hFF90, 2'd1);
      tick();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
